// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
// Holds the FSM encoding, frame-length constants and the pointer-width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Width of a requester index; at least one bit, even with a single requester.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_lock.sv
// Round-robin one-hot grant over an eligibility vector.
// Search starts one past the pointer and wraps modulo N_REQ.
module rr_arb_lock #(
    parameter int N_REQ = 2,
    parameter int PW    = 1
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant
);

    logic [PW-1:0] idx;
    logic          found;

    // First eligible requester after the pointer wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = PW'((int'(ptr) + i) % N_REQ);
            if (!found && elig[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shared 8N1 UART transmitter with round-robin requester arbitration.
// Owners may lock the line across bytes; bytes go out LSB first.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int DIV_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [DIV_W-1:0]   clkdiv,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_lock,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   owner,
    output logic               tx,
    output logic               busy
);

    localparam int PW = ptr_w(N_REQ);

    tx_state_t        state;
    tx_state_t        state_nxt;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] div_lat;
    logic [DIV_W-1:0] lat_nxt;
    logic [7:0]       shreg;
    logic [7:0]       sh_nxt;
    logic             tx_nxt;

    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    win_idx;
    logic [7:0]       win_data;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] grant;
    logic             locked;
    logic             div_zero;
    logic             window;
    logic             accept;

    assign div_zero = (div_cnt == '0);
    assign window   = (state == IDLE) ||
                      (state == STOP && div_zero &&
                       bit_cnt == 3'(STOP_BITS - 1));

    // A locking owner masks everyone else, even while it has nothing to send.
    assign locked = |(owner & req_lock);
    assign elig   = locked ? (owner & req_valid) : req_valid;

    rr_arb_lock #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .elig  (elig),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign accept    = enable && window && (|grant);
    assign req_ready = accept ? grant : '0;
    assign busy      = (state != IDLE);

    // Winner index and its byte, selected from the one-hot grant.
    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (grant[j]) begin
                win_idx  = PW'(j);
                win_data = req_data[8*j +: 8];
            end
        end
    end

    // Serialiser next-state: bit sequencing, divisor reload and accept restart.
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        div_nxt   = div_cnt;
        lat_nxt   = div_lat;
        sh_nxt    = shreg;
        unique case (state)
            IDLE: begin
            end
            START: begin
                if (div_zero) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                    div_nxt   = div_lat;
                end else begin
                    div_nxt = div_cnt - DIV_W'(1);
                end
            end
            DATA: begin
                if (div_zero) begin
                    div_nxt = div_lat;
                    sh_nxt  = {1'b0, shreg[7:1]};
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        state_nxt = STOP;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end else begin
                    div_nxt = div_cnt - DIV_W'(1);
                end
            end
            STOP: begin
                if (div_zero) begin
                    div_nxt = div_lat;
                    if (bit_cnt == 3'(STOP_BITS - 1)) begin
                        state_nxt = IDLE;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end else begin
                    div_nxt = div_cnt - DIV_W'(1);
                end
            end
        endcase
        if (accept) begin
            state_nxt = START;
            bit_nxt   = '0;
            div_nxt   = clkdiv;
            lat_nxt   = clkdiv;
            sh_nxt    = win_data;
        end
    end

    // Line level for the next cycle, so the pad is driven from a flop.
    always_comb begin
        tx_nxt = 1'b1;
        unique case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = sh_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    // Serialiser state; reset drops any frame and idles the line at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            div_cnt <= '0;
            div_lat <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_nxt;
            div_cnt <= div_nxt;
            div_lat <= lat_nxt;
            shreg   <= sh_nxt;
            tx      <= tx_nxt;
        end
    end

    // Ownership and round-robin pointer follow the last accepted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner  <= '0;
            rr_ptr <= PW'(N_REQ - 1);
        end else if (accept) begin
            owner  <= grant;
            rr_ptr <= win_idx;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a behavioural receiver decodes tx
// and checks every frame against the queue filled by the stimulus.
module tb_uart_tx_sched;

    localparam int N  = 2;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] clkdiv = '0;
    logic [N-1:0]  req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]  req_lock = '0;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  owner;
    logic          tx;
    logic          busy;

    uart_tx_sched #(
        .N_REQ (N),
        .DIV_W (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clkdiv    (clkdiv),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .owner     (owner),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         per;
        bit         b2b;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rx_cnt = 0;
    int   rx_start = 0;
    int   last_end = -100;
    bit   rx_en = 1'b1;
    int   acc_cyc = 0;
    int   prev_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input int per, input bit b2b);
        exp_t e;
        e.data = d;
        e.per  = per;
        e.b2b  = b2b;
        sb.push_back(e);
    endtask

    // Call right after driving inputs at a negedge; returns in the accept cycle.
    task automatic wait_rdy(input string tag, input logic [N-1:0] exp);
        int k;
        k = 0;
        #1;
        while (req_ready == '0 && k < 500) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(tag, req_ready, exp);
        prev_acc = acc_cyc;
        acc_cyc  = cyc;
    endtask

    task automatic wait_rx(input int n);
        int k;
        k = 0;
        while (rx_cnt < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("rx_timeout", 32'(rx_cnt >= n), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Behavioural receiver: checks every sample of each frame, decodes mid-bit.
    initial begin : rx_model
        exp_t       e;
        logic [7:0] rx;
        int         bad;
        int         b;
        int         k;
        logic       eb;
        forever begin
            @(posedge clk);
            #1;
            if (rx_en && rst_n && tx === 1'b0) begin
                if (sb.size() == 0) begin
                    chk("rx_unexp", 1, 0);
                    k = 0;
                    while (tx === 1'b0 && k < 2000) begin
                        @(posedge clk);
                        #1;
                        k++;
                    end
                end else begin
                    e = sb.pop_front();
                    if (e.b2b) chk("rx_gap", 32'(cyc - last_end), 1);
                    rx_start = cyc;
                    rx  = '0;
                    bad = 0;
                    for (int n = 0; n < 10 * e.per; n++) begin
                        if (n > 0) begin
                            @(posedge clk);
                            #1;
                        end
                        b  = n / e.per;
                        eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b-1];
                        if (tx !== eb) bad++;
                        if (b >= 1 && b <= 8 && n % e.per == e.per / 2)
                            rx[b-1] = tx;
                    end
                    chk("rx_byte", rx, e.data);
                    chk("rx_shape", bad, 0);
                    last_end = cyc;
                    rx_cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : main
        int r;
        int bz;
        int tl;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_owner", owner, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Single byte at 4 cycles per bit.
        push(8'hA5, 4, 1'b0);
        @(negedge clk);
        clkdiv = 16'd3;
        req_data[7:0] = 8'hA5;
        req_valid = 2'b01;
        wait_rdy("sb_rdy", 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("sb_owner", owner, 2'b01);
        chk("sb_busy", busy, 1);
        wait_rx(1);
        chk("sb_lat", 32'(rx_start - acc_cyc), 1);
        chk("sb_busy_last", busy, 1);
        @(posedge clk);
        #1;
        chk("sb_busy_end", busy, 0);
        chk("sb_tx_idle", tx, 1);

        // Round-robin from a fresh pointer, back-to-back 10-cycle frames.
        do_reset();
        push(8'h11, 1, 1'b0);
        push(8'h22, 1, 1'b1);
        push(8'h11, 1, 1'b1);
        push(8'h22, 1, 1'b1);
        @(negedge clk);
        clkdiv    = 16'd0;
        req_data  = {8'h22, 8'h11};
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            wait_rdy("rr_grant", (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) chk("rr_period", 32'(acc_cyc - prev_acc), 10);
        end
        @(negedge clk);
        req_valid = 2'b00;
        wait_rx(5);

        // Lock: req1 owns the line, req0 stalls through req1's gap.
        @(negedge clk);
        chk("lk_own0", owner, 2'b10);
        push(8'h48, 1, 1'b0);
        push(8'h49, 1, 1'b0);
        push(8'hC3, 1, 1'b1);
        req_data  = {8'h48, 8'hC3};
        req_lock  = 2'b10;
        req_valid = 2'b11;
        wait_rdy("lk_rdy48", 2'b10);
        @(negedge clk);
        req_valid = 2'b01;
        r = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            #1;
            if (req_ready != '0) r++;
        end
        chk("lk_stall", r, 0);
        chk("lk_idle", busy, 0);
        req_data[15:8] = 8'h49;
        req_valid = 2'b11;
        wait_rdy("lk_rdy49", 2'b10);
        @(negedge clk);
        req_valid = 2'b01;
        req_lock  = 2'b00;
        wait_rdy("lk_rdyC3", 2'b01);
        chk("lk_b2b", 32'(acc_cyc - prev_acc), 10);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rx(8);

        // clkdiv change mid-frame only affects the following frame.
        push(8'h5A, 4, 1'b0);
        push(8'h3C, 8, 1'b1);
        @(negedge clk);
        clkdiv = 16'd3;
        req_data[7:0] = 8'h5A;
        req_valid = 2'b01;
        wait_rdy("cd_rdy0", 2'b01);
        @(negedge clk);
        clkdiv = 16'd7;
        req_data[7:0] = 8'h3C;
        wait_rdy("cd_rdy1", 2'b01);
        chk("cd_period", 32'(acc_cyc - prev_acc), 40);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rx(10);

        // enable dropped during DATA: frame finishes, then nothing is accepted.
        push(8'h96, 2, 1'b0);
        @(negedge clk);
        clkdiv = 16'd1;
        req_data[7:0] = 8'h96;
        req_valid = 2'b01;
        wait_rdy("en_rdy0", 2'b01);
        @(negedge clk);
        req_data[7:0] = 8'h69;
        repeat (6) @(negedge clk);
        enable = 1'b0;
        wait_rx(11);
        @(posedge clk);
        r  = 0;
        bz = 0;
        tl = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (req_ready != '0) r++;
            if (busy !== 1'b0) bz++;
            if (tx !== 1'b1) tl++;
        end
        chk("en_noready", r, 0);
        chk("en_nobusy", bz, 0);
        chk("en_txhigh", tl, 0);
        push(8'h69, 2, 1'b0);
        @(negedge clk);
        enable = 1'b1;
        wait_rdy("en_rdy1", 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rx(12);

        // Asynchronous reset during DATA bit 3.
        rx_en = 1'b0;
        @(negedge clk);
        clkdiv = 16'd3;
        req_data[15:8] = 8'hF0;
        req_valid = 2'b10;
        wait_rdy("rs_rdy", 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (17) @(negedge clk);
        chk("rs_busy_pre", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_tx", tx, 1);
        chk("rs_busy", busy, 0);
        chk("rs_owner", owner, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tl = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) tl++;
        end
        chk("rs_quiet", tl, 0);
        rx_en = 1'b1;
        push(8'h33, 4, 1'b0);
        push(8'h44, 4, 1'b1);
        @(negedge clk);
        req_data  = {8'h44, 8'h33};
        req_valid = 2'b11;
        wait_rdy("rs_rdy0", 2'b01);
        @(negedge clk);
        req_valid = 2'b10;
        wait_rdy("rs_rdy1", 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rx(14);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
